pkt_read_arbiter: RTL and testbench

- Shares the single read port of pkt_centralize_bufm_memory among 4 network_tx read requesters.
- Each requester's pkt_read_control issues read addresses through this block; the block arbitrates round-robin and forwards one read per cycle to memory.
- Read data returns after a fixed latency and is routed back to the port that issued the read, using an in-flight tag pipeline.

---
 rtl/pkt_read_arbiter.sv | 156 +++++++++++++++
 tb/tb_pkt_read_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_read_arbiter.sv
// Round-robin arbiter sharing one memory read port among four requesters, with a
// tag pipe that routes returning data back. Define P0_STRICT_PRIORITY_EN to give port 0 strict priority.
module pkt_read_arbiter #(
    parameter int RD_LATENCY = 2,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [15:0]          iv_pkt_raddr_p0,
    input  logic [15:0]          iv_pkt_raddr_p1,
    input  logic [15:0]          iv_pkt_raddr_p2,
    input  logic [15:0]          iv_pkt_raddr_p3,
    input  logic                 i_pkt_rd_p0,
    input  logic                 i_pkt_rd_p1,
    input  logic                 i_pkt_rd_p2,
    input  logic                 i_pkt_rd_p3,
    output logic                 o_pkt_raddr_ack_p0,
    output logic                 o_pkt_raddr_ack_p1,
    output logic                 o_pkt_raddr_ack_p2,
    output logic                 o_pkt_raddr_ack_p3,
    output logic [15:0]          ov_pkt_raddr,
    output logic                 o_pkt_rd,
    input  logic [133:0]         iv_pkt_data,
    input  logic                 i_pkt_data_wr,
    output logic [133:0]         ov_pkt_data,
    output logic                 o_pkt_data_wr_p0,
    output logic                 o_pkt_data_wr_p1,
    output logic                 o_pkt_data_wr_p2,
    output logic                 o_pkt_data_wr_p3,
    output logic                 o_rd_err_pulse,
    output logic [ERR_CNT_W-1:0] ov_rd_err_cnt
);

    logic [3:0]  req;
    logic [3:0]  ack_q;
    logic [3:0]  eligible;
    logic [1:0]  last_grant;
    logic [1:0]  grant_id;
    logic        win_valid;
    logic [1:0]  win_id;
    logic [1:0]  idx;
    logic [15:0] win_addr;
    logic [3:0]  data_wr_q;
    logic        tag_v  [RD_LATENCY];
    logic [1:0]  tag_id [RD_LATENCY];
    logic        tail_v;
    logic [1:0]  tail_id;
    logic        mismatch;

    assign req = {i_pkt_rd_p3, i_pkt_rd_p2, i_pkt_rd_p1, i_pkt_rd_p0};
    assign {o_pkt_raddr_ack_p3, o_pkt_raddr_ack_p2, o_pkt_raddr_ack_p1, o_pkt_raddr_ack_p0} = ack_q;
    assign {o_pkt_data_wr_p3, o_pkt_data_wr_p2, o_pkt_data_wr_p1, o_pkt_data_wr_p0} = data_wr_q;

    assign tail_v   = tag_v[RD_LATENCY-1];
    assign tail_id  = tag_id[RD_LATENCY-1];
    assign mismatch = i_pkt_data_wr ^ tail_v;

    // A port acked this cycle is masked so a held request is not granted twice.
    always_comb begin
        eligible  = req & ~ack_q;
        win_valid = 1'b0;
        win_id    = 2'd0;
        idx       = 2'd0;
`ifdef P0_STRICT_PRIORITY_EN
        if (eligible[0]) begin
            win_valid = 1'b1;
            win_id    = 2'd0;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = last_grant + k[1:0];
                if (!win_valid && idx != 2'd0 && eligible[idx]) begin
                    win_valid = 1'b1;
                    win_id    = idx;
                end
            end
        end
`else
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + k[1:0];
            if (!win_valid && eligible[idx]) begin
                win_valid = 1'b1;
                win_id    = idx;
            end
        end
`endif
    end

    always_comb begin
        win_addr = iv_pkt_raddr_p0;
        case (win_id)
            2'd1:    win_addr = iv_pkt_raddr_p1;
            2'd2:    win_addr = iv_pkt_raddr_p2;
            2'd3:    win_addr = iv_pkt_raddr_p3;
            default: win_addr = iv_pkt_raddr_p0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q        <= 4'd0;
            o_pkt_rd     <= 1'b0;
            ov_pkt_raddr <= 16'd0;
            last_grant   <= 2'd3;
            grant_id     <= 2'd0;
        end else begin
            ack_q    <= 4'd0;
            o_pkt_rd <= win_valid;
            if (win_valid) begin
                ov_pkt_raddr  <= win_addr;
                ack_q[win_id] <= 1'b1;
                grant_id      <= win_id;
`ifdef P0_STRICT_PRIORITY_EN
                if (win_id != 2'd0)
                    last_grant <= win_id;
`else
                last_grant <= win_id;
`endif
            end
        end
    end

    // Stage 0 captures the read issued this cycle; the tail lines up with memory data valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= 2'd0;
            end
        end else begin
            tag_v[0]  <= o_pkt_rd;
            tag_id[0] <= grant_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_pkt_data    <= '0;
            data_wr_q      <= 4'd0;
            o_rd_err_pulse <= 1'b0;
            ov_rd_err_cnt  <= '0;
        end else begin
            if (i_pkt_data_wr)
                ov_pkt_data <= iv_pkt_data;
            for (int n = 0; n < 4; n++)
                data_wr_q[n] <= i_pkt_data_wr & tail_v & (tail_id == n[1:0]);
            o_rd_err_pulse <= mismatch;
            if (mismatch && ov_rd_err_cnt != {ERR_CNT_W{1'b1}})
                ov_rd_err_cnt <= ov_rd_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pkt_read_arbiter.sv
// Directed bench for pkt_read_arbiter; a small memory model returns data
// RD_LATENCY cycles after each read strobe.
module tb_pkt_read_arbiter;

    localparam int L = 2;

    logic         clk;
    logic         rst_n;
    logic [15:0]  addr [4];
    logic [3:0]   req;
    logic [133:0] mem_data;
    logic         mem_wr;
    logic         auto_wr;
    logic         inj;
    logic         drop;
    logic [7:0]   rd_hist;
    logic [3:0]   ack;
    logic [3:0]   dwr;
    logic [15:0]  raddr;
    logic         rd;
    logic [133:0] data_out;
    logic         err_pulse;
    logic [15:0]  err_cnt;
    int           dwr_cnt [4];
    int           n_vec;
    int           n_err;

    pkt_read_arbiter #(.RD_LATENCY(L), .ERR_CNT_W(16)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .iv_pkt_raddr_p0    (addr[0]),
        .iv_pkt_raddr_p1    (addr[1]),
        .iv_pkt_raddr_p2    (addr[2]),
        .iv_pkt_raddr_p3    (addr[3]),
        .i_pkt_rd_p0        (req[0]),
        .i_pkt_rd_p1        (req[1]),
        .i_pkt_rd_p2        (req[2]),
        .i_pkt_rd_p3        (req[3]),
        .o_pkt_raddr_ack_p0 (ack[0]),
        .o_pkt_raddr_ack_p1 (ack[1]),
        .o_pkt_raddr_ack_p2 (ack[2]),
        .o_pkt_raddr_ack_p3 (ack[3]),
        .ov_pkt_raddr       (raddr),
        .o_pkt_rd           (rd),
        .iv_pkt_data        (mem_data),
        .i_pkt_data_wr      (mem_wr),
        .ov_pkt_data        (data_out),
        .o_pkt_data_wr_p0   (dwr[0]),
        .o_pkt_data_wr_p1   (dwr[1]),
        .o_pkt_data_wr_p2   (dwr[2]),
        .o_pkt_data_wr_p3   (dwr[3]),
        .o_rd_err_pulse     (err_pulse),
        .ov_rd_err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_wr = (auto_wr & ~drop) | inj;

    // Memory model: a read seen in cycle c returns data in cycle c+L.
    always @(negedge clk) begin
        auto_wr = rd_hist[L-1];
        rd_hist = {rd_hist[6:0], rd};
        for (int n = 0; n < 4; n++)
            if (dwr[n]) dwr_cnt[n] = dwr_cnt[n] + 1;
    end

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req = 4'd0;
        repeat (L + 4) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // seq holds expected winners, first grant in the low two bits.
    task automatic run_seq(input string tag, input logic [3:0] mask, input int n, input logic [15:0] seq);
        logic [1:0] id;
        req = mask;
        for (int i = 0; i < n; i++) begin
            tick();
            id = seq[2*i +: 2];
            chk({tag, "_ack"}, ack, 4'b0001 << id);
            chk({tag, "_rd"}, rd, 1'b1);
            chk({tag, "_addr"}, raddr, addr[id]);
        end
        req = 4'd0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        req      = 4'd0;
        inj      = 1'b0;
        drop     = 1'b0;
        auto_wr  = 1'b0;
        rd_hist  = 8'd0;
        mem_data = 134'h2A_5A5A_0000_1234_DEAD_BEEF;
        for (int n = 0; n < 4; n++) begin
            addr[n]    = 16'h0121 + 16'(n);
            dwr_cnt[n] = 0;
        end
        repeat (3) tick();
        chk("rst_rd", rd, 1'b0);
        chk("rst_ack", ack, 4'd0);
        chk("rst_addr", raddr, 16'd0);
        chk("rst_data", data_out, 134'd0);
        chk("rst_dwr", dwr, 4'd0);
        chk("rst_pulse", err_pulse, 1'b0);
        chk("rst_cnt", err_cnt, 16'd0);
        rst_n = 1'b1;
        tick();

        // single request on port 2
        req = 4'b0100;
        tick();
        chk("single_rd", rd, 1'b1);
        chk("single_addr", raddr, 16'h0123);
        chk("single_ack", ack, 4'b0100);
        req = 4'd0;
        tick();
        chk("single_ack_once", ack, 4'd0);
        repeat (L) tick();
        chk("single_dwr", dwr, 4'b0100);
        chk("single_data", data_out, mem_data);
        chk("single_pulse", err_pulse, 1'b0);
        tick();
        chk("single_dwr_once", dwr, 4'd0);
        drain();

        // all four ports held
        do_reset();
        for (int n = 0; n < 4; n++) dwr_cnt[n] = 0;
        run_seq("all4", 4'b1111, 8, {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0});
        drain();
        chk("all4_cnt", err_cnt, 16'd0);
        for (int n = 0; n < 4; n++) chk("all4_route", dwr_cnt[n], 2);

        // ports 1 and 3 alternate
        run_seq("p1p3", 4'b1010, 4, {2'd3, 2'd1, 2'd3, 2'd1});
        drain();
        chk("p1p3_cnt", err_cnt, 16'd0);

        do_reset();
        run_seq("p0p2", 4'b0101, 4, {2'd2, 2'd0, 2'd2, 2'd0});
        drain();

        do_reset();
`ifdef P0_STRICT_PRIORITY_EN
        run_seq("p012", 4'b0111, 4, {2'd2, 2'd0, 2'd1, 2'd0});
`else
        run_seq("p012", 4'b0111, 4, {2'd0, 2'd2, 2'd1, 2'd0});
`endif
        drain();
        chk("p012_cnt", err_cnt, 16'd0);

        // spurious data valid, then a dropped return
        do_reset();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("inj_pulse", err_pulse, 1'b1);
        chk("inj_cnt", err_cnt, 16'd1);
        chk("inj_dwr", dwr, 4'd0);
        tick();
        chk("inj_pulse_clr", err_pulse, 1'b0);
        drop = 1'b1;
        req  = 4'b0001;
        tick();
        chk("drop_ack", ack, 4'b0001);
        req = 4'd0;
        repeat (L + 1) tick();
        chk("drop_pulse", err_pulse, 1'b1);
        chk("drop_cnt", err_cnt, 16'd2);
        chk("drop_dwr", dwr, 4'd0);
        drop = 1'b0;
        drain();

        // reset with two reads in flight
        do_reset();
        req = 4'b1010;
        tick();
        chk("flight_ack1", ack, 4'b0010);
        tick();
        req = 4'd0;
        chk("flight_ack3", ack, 4'b1000);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rd", rd, 1'b0);
        chk("async_ack", ack, 4'd0);
        chk("async_addr", raddr, 16'd0);
        #1 rst_n = 1'b1;
        tick();
        tick();
        chk("flight_pulse", err_pulse, 1'b1);
        tick();
        chk("flight_cnt", err_cnt, 16'd2);
        chk("flight_dwr", dwr, 4'd0);
        req = 4'b1111;
        tick();
        chk("flight_next", ack, 4'b0001);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
